// File: rtl/aesdecipher.sv
// aesdecipher: iterative AES-256 inverse cipher (FIPS-197, Nk=8, Nr=14).
//   clk      : clock, all state changes on the rising edge
//   rst_n    : synchronous active-low reset
//   start    : begin decrypting datain with key (sampled only when idle)
//   key      : 256-bit cipher key, byte 0 in [255:248]
//   datain   : 128-bit ciphertext, byte 0 in [127:120]
//   dataout  : registered plaintext, held until the next completion
//   done     : one-cycle pulse when dataout is updated
//   busy     : high while an operation is in progress
// Build option AESDEC_KEYCACHE_EN: keep the last expanded key schedule and
// skip expansion when the next key matches it (15-cycle latency instead of 28).
module aesdecipher (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [127:0] datain,
    output logic [127:0] dataout,
    output logic         done,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXPAND, ROUND} state_e;

    state_e       fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;   // EXPAND: index of key being built; ROUND: round key index
    logic [127:0] st_q, st_d;
    logic [127:0] dout_q, dout_d;
    logic         done_q, done_d;
    logic [127:0] rk_q [15];
    logic [127:0] rk_d [15];
    logic         cache_hit;
`ifdef AESDEC_KEYCACHE_EN
    logic         kv_q, kv_d;
    // rk0/rk1 are the raw key, so they double as the cached key tag
    assign cache_hit = kv_q && (key == {rk_q[0], rk_q[1]});
`else
    assign cache_hit = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // inverse affine transform, then field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    // Round key idx (2..14) from the two preceding round keys.
    function automatic logic [127:0] next_rk(input logic [127:0] p2, input logic [127:0] p1,
                                             input logic [3:0] idx);
        logic [31:0] t, w0, w1, w2, w3;
        logic [7:0]  rc;
        t  = p1[31:0];
        rc = 8'h01 << (idx[3:1] - 3'd1);
        if (!idx[0])
            t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        else
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        w0 = p2[127:96] ^ t;
        w1 = p2[95:64]  ^ w0;
        w2 = p2[63:32]  ^ w1;
        w3 = p2[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last.
    // Byte n = row r + 4*col c; row r is rotated right by r columns.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]) ^ k[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = last ? t[4*c+r] :
                    gmul(t[4*c+r], 8'h0e)         ^ gmul(t[4*c+(r+1)%4], 8'h0b) ^
                    gmul(t[4*c+(r+2)%4], 8'h0d)   ^ gmul(t[4*c+(r+3)%4], 8'h09);
        return o;
    endfunction

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        dout_d = dout_q;
        done_d = 1'b0;
        rk_d   = rk_q;
`ifdef AESDEC_KEYCACHE_EN
        kv_d   = kv_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    st_d = datain;
                    if (cache_hit) begin
                        fsm_d = ROUND;
                        cnt_d = 4'd14;
                    end else begin
                        rk_d[0] = key[255:128];
                        rk_d[1] = key[127:0];
                        fsm_d   = EXPAND;
                        cnt_d   = 4'd2;
`ifdef AESDEC_KEYCACHE_EN
                        kv_d    = 1'b0;
`endif
                    end
                end
            end
            EXPAND: begin
                rk_d[cnt_q] = next_rk(rk_q[cnt_q - 4'd2], rk_q[cnt_q - 4'd1], cnt_q);
                if (cnt_q == 4'd14) begin
                    fsm_d = ROUND;   // cnt stays 14: first round uses rk14
`ifdef AESDEC_KEYCACHE_EN
                    kv_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                if (cnt_q == 4'd14) begin
                    st_d  = st_q ^ rk_q[14];
                    cnt_d = 4'd13;
                end else begin
                    st_d = inv_round(st_q, rk_q[cnt_q], cnt_q == 4'd0);
                    if (cnt_q == 4'd0) begin
                        dout_d = st_d;
                        done_d = 1'b1;
                        fsm_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            cnt_q  <= 4'd0;
            st_q   <= '0;
            dout_q <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < 15; i++) rk_q[i] <= '0;
`ifdef AESDEC_KEYCACHE_EN
            kv_q   <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            dout_q <= dout_d;
            done_q <= done_d;
            rk_q   <= rk_d;
`ifdef AESDEC_KEYCACHE_EN
            kv_q   <= kv_d;
`endif
        end
    end

    assign dataout = dout_q;
    assign done    = done_q;
    assign busy    = (fsm_q != IDLE);
endmodule

// File: tb/tb_aesdecipher.sv
module tb_aesdecipher;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] key = '0;
    logic [127:0] datain = '0;
    logic [127:0] dataout;
    logic         done;
    logic         busy;

    aesdecipher dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .datain(datain),
        .dataout(dataout), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;
    exp_t exp_q[$];

    // model of the optional key cache
    logic         mc_v = 1'b0;
    logic [255:0] mc_key = '0;

    logic [7:0] sb [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    // Forward S-box via exp/log tables over generator 3.
    task automatic build_sbox();
        logic [7:0] ex [255];
        int         lg [256];
        logic [7:0] e, inv;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = e;
            lg[e] = i;
            e = e ^ xt(e);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-256 encryption: the bench encrypts random plaintext and
    // expects the DUT to recover it.
    function automatic logic [127:0] enc(input logic [255:0] k, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] o;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            end
            w[i] = w[i-8] ^ t;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8];
        for (int rnd = 0; rnd <= 14; rnd++) begin
            if (rnd > 0) begin
                for (int n = 0; n < 16; n++) u[n] = sb[s[n]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) s[r+4*c] = u[r+4*((c+r)%4)];
                if (rnd < 14)
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end
            end
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[4*rnd+c][31-8*j -: 8];
        end
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
        return o;
    endfunction

    // Called at a point where the DUT is idle (or showing done); E0 is the next posedge.
    task automatic issue(input logic [255:0] k, input logic [127:0] ct, input logic [127:0] pt);
        exp_t e;
        int   lat;
        start  = 1'b1;
        key    = k;
        datain = ct;
        @(negedge clk);
        start = 1'b0;
        lat = 28;
`ifdef AESDEC_KEYCACHE_EN
        if (mc_v && k == mc_key) lat = 15;
        mc_v   = 1'b1;
        mc_key = k;
`endif
        e.pt  = pt;
        e.due = cyc + lat;
        exp_q.push_back(e);
        check("busy_after_start", {127'd0, busy}, 128'd1);
    endtask

    // Returns in the cycle done is high, so the next issue() restarts back to back.
    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: %0d results outstanding after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    // Monitor: every done pulse is matched against the scoreboard.
    exp_t got;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: done high with nothing outstanding, dataout %h", dataout);
            end else begin
                got = exp_q.pop_front();
                check("plaintext", dataout, got.pt);
                check("latency_cycle", 128'(cyc), 128'(got.due));
                check("busy_at_done", {127'd0, busy}, 128'd0);
            end
        end
    end

    localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K2  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] C2  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] k;
        logic [127:0] pt;
        int           n;
        logic         held;

        build_sbox();

        // reset state, then idle with no start
        repeat (3) @(negedge clk);
        check("reset_dataout", dataout, 128'd0);
        check("reset_done", {127'd0, done}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_dataout", dataout, 128'd0);
            check("idle_done", {127'd0, done}, 128'd0);
        end

        // known-answer vectors, issued back to back in the done cycle
        issue(K1, C1, P1);
        wait_idle();
        issue(K2, C2, P2);
        wait_idle();
        issue(K1, C1, P1);
        wait_idle();
        issue(K1, C1, P1);   // same key again: cache hit when the cache is built in
        wait_idle();

        // inputs changed and start pulsed mid-operation are ignored
        k  = rnd256();
        pt = {$urandom, $urandom, $urandom, $urandom};
        issue(k, enc(k, pt), pt);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        key    = rnd256();
        datain = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        held = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            if (!busy) held = 1'b0;
            @(negedge clk);
            n++;
        end
        check("busy_held_until_done", {127'd0, held}, 128'd1);
        wait_idle();

        // reset in the middle of an operation aborts it
        @(negedge clk);
        issue(K2, C2, P2);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        mc_v = 1'b0;
        @(negedge clk);
        check("abort_dataout", dataout, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_done", {127'd0, done}, 128'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {127'd0, done}, 128'd0);
        end
        issue(K2, C2, P2);
        wait_idle();

        // random traffic, roughly half reusing the previous key
        k = rnd256();
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(1, 0) == 0) k = rnd256();
            pt = {$urandom, $urandom, $urandom, $urandom};
            issue(k, enc(k, pt), pt);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
